// File: rtl/timer_sequencer_if.sv
// Request port of the timer sequencer: a one-way stream of terminal counts.
// A transfer happens on every rising clk where req_valid && req_ready; req_data is only meaningful while req_valid is high.
interface timer_sequencer_if #(
  parameter int Width = 4
);
  logic             req_valid;
  logic [Width-1:0] req_data;
  logic             req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/timer_sequencer.sv
// Queues interval requests and drives the 4-bit interval timer through
// clear / load / count phases, one queued interval at a time.
module timer_sequencer #(
  parameter int Width = 4,
  parameter int Depth = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  timer_sequencer_if.slave       req,
  input  logic                   abort_i,
  output logic                   tmr_srst_o,
  output logic                   tmr_start_o,
  output logic [Width-1:0]       tmr_data_o,
  input  logic                   tmr_stop_i,
  output logic                   done_o,
  output logic                   aborted_o,
  output logic                   busy_o,
  output logic [$clog2(Depth):0] fifo_level_o,
  output logic [1:0]             state_o
);
  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] One = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [Width-1:0] tmr_data_q;
  logic             tmr_srst_q, tmr_start_q, done_q, aborted_q;
  logic             full, empty, push, pop;

  // Full/empty come from registered pointers only, so a pop never frees a slot in the same cycle.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = req.req_valid && !full;
  assign pop   = ((state_q == IDLE) || (state_q == DONE)) && !empty;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + One : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + One : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + One;
    end else if (!push && pop) begin
      level_d = level_q - One;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= req.req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Outputs are registered alongside the state they belong to; an abort reuses DONE with aborted_q instead of done_q.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      tmr_srst_q  <= 1'b1;
      tmr_start_q <= 1'b0;
      tmr_data_q  <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          tmr_srst_q  <= 1'b1;
          tmr_start_q <= 1'b0;
          if (pop) begin
            state_q    <= CLEAR;
            tmr_data_q <= mem_q[rd_ptr_q[AW-1:0]];
          end else begin
            state_q <= IDLE;
          end
        end
        CLEAR: begin
          if (abort_i) begin
            state_q   <= DONE;
            aborted_q <= 1'b1;
          end else begin
            state_q     <= RUN;
            tmr_srst_q  <= 1'b0;
            tmr_start_q <= 1'b1;
          end
        end
        RUN: begin
          if (tmr_stop_i || abort_i) begin
            state_q     <= DONE;
            tmr_srst_q  <= 1'b1;
            tmr_start_q <= 1'b0;
            done_q      <= tmr_stop_i;
            aborted_q   <= !tmr_stop_i;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req.req_ready = !full;
  assign tmr_srst_o    = tmr_srst_q;
  assign tmr_start_o   = tmr_start_q;
  assign tmr_data_o    = tmr_data_q;
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;
  assign busy_o        = (state_q != IDLE);
  assign fifo_level_o  = level_q;
  assign state_o       = state_q;
endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Upstream controller for the 4-bit interval timer. Accepts interval requests through a valid/ready port, buffers them in a small FIFO and plays them back one at a time. For each interval it clears the timer, loads the terminal count, enables counting and waits for the timer's stop flag. It then reports completion and moves to the next queued interval.

## Interface
- Width, 4, interval/terminal-count width; must match the timer's Width
- Depth, 4, request FIFO depth in entries; power of two, ≥2
- clk  in  1  clock; all logic on rising edge
- srst  in  1  synchronous reset, active-high
- req_valid  in  1  interval request present
- req_data  in  Width  terminal count for the request
- req_ready  out  1  FIFO can accept; equals !full (registered state)
- abort  in  1  single-cycle pulse; cancels the interval in progress
- tmr_srst  out  1  clear to timer; drives timer's srst
- tmr_start  out  1  count enable to timer
- tmr_data  out  Width  terminal count to timer; held stable for whole interval
- tmr_stop  in  1  timer stop flag; sampled on rising clk
- done  out  1  one-cycle pulse: interval completed normally
- aborted  out  1  one-cycle pulse: interval cancelled by abort
- busy  out  1  high in CLEAR, RUN, DONE
- fifo_level  out  $clog2(Depth)+1  entries currently queued

## Operation
- Reset (srst=1): FIFO empty, state IDLE, req_ready=1, tmr_srst=1, tmr_start=0, tmr_data=0, done=0, aborted=0, busy=0, fifo_level=0. Reset mid-interval discards the interval and all queued entries, with no done or aborted pulse.
- Push: on req_valid && req_ready. Full is evaluated on registered state, so a push is refused while full even if a pop happens in the same cycle. Push and pop in the same cycle leave fifo_level unchanged.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - tmr_srst=1, tmr_start=0.
  - If FIFO is non-empty, pop the head into tmr_data and go to CLEAR.
- CLEAR: exactly 1 cycle; tmr_srst=1, tmr_start=0; then RUN. This guarantees tmr_stop is low at the first RUN sample.
- RUN:
  - tmr_srst=0, tmr_start=1.
  - On the first cycle sampling tmr_stop=1, go to DONE.
  - With the standard timer, RUN lasts tmr_data+1 cycles. tmr_data=0 gives 1 RUN cycle.
- DONE:
  - 1 cycle; done=1, tmr_start=0, tmr_srst=1.
  - If the FIFO is non-empty, pop the head and go to CLEAR (back-to-back). Otherwise go to IDLE.
- abort:
  - Honoured only in CLEAR or RUN. Sets aborted=1 in the next cycle and forces the state to DONE-equivalent handling without done. In that cycle tmr_start=0, tmr_srst=1 and the next entry is popped if present.
  - Queued entries are kept.
  - abort in IDLE or DONE is ignored.
- abort and tmr_stop=1 sampled in the same RUN cycle: stop wins; done=1, aborted=0.
- done and aborted are mutually exclusive and never asserted in consecutive cycles for the same interval.
- fifo_level wraps never; pointers are $clog2(Depth) bits with an extra wrap bit for full/empty.

## Timing
- Request to first tmr_start with an idle, empty sequencer:
  - push at edge 0;
  - IDLE sees non-empty at edge 1, going to CLEAR;
  - RUN begins after edge 2.
  - tmr_start rises 2 cycles after the accepting edge.
- Completion: done is high in the cycle after the last RUN cycle.
- Back-to-back: interval n+1 enters CLEAR in the cycle after DONE of interval n. Gap with tmr_start low = 2 cycles (DONE + CLEAR).
- tmr_data changes only on a pop. It is stable throughout CLEAR and RUN.
- All outputs are registered except req_ready and busy, which are decoded from registered state.

## Test plan
- Reset values: hold srst 3 cycles → req_ready=1, tmr_srst=1, tmr_start=0, done=0, aborted=0, busy=0, fifo_level=0.
- Single interval: push req_data=5 with the timer model attached → tmr_start high for exactly 6 cycles, then done pulses once and the FSM returns to IDLE; tmr_data=5 throughout.
- Queue and back-to-back:
  - push 3, 0, 15 on consecutive cycles → fifo_level peaks at 2 (the first entry is popped immediately).
  - RUN lengths are 4, 1 and 16 cycles, each separated by exactly 2 idle-start cycles.
  - 3 done pulses in total.
- Full FIFO (Depth=4):
  - while interval 1 runs, push 5 more → exactly 4 are accepted and req_ready=0 with fifo_level=4.
  - the 5th request is held until the next pop, then accepted.
- Abort:
  - abort in the 3rd RUN cycle of data=10 with 1 entry queued → aborted pulses, no done, the queued interval starts via CLEAR next.
  - abort coincident with tmr_stop → done only.
- srst mid-RUN with 2 entries queued → the next cycle shows reset values and fifo_level=0, with no done or aborted pulse.
